fetch_stall_ctrl: RTL and testbench

Front-end pipeline controller that consumes the hazard unit's stall requests. It owns the PC register, the IF/ID pipeline register and the boot counter that the hazard unit reads. It applies stalls, mispredict redirects and predicted-taken redirects with a fixed priority. It drives the bubble request into ID/EX and keeps stall/flush performance counters.

---
 rtl/rv32_pkg.sv | 20 ++
 rtl/perf_counter.sv | 31 +++
 rtl/fetch_stall_ctrl.sv | 87 ++++++++
 tb/tb_fetch_stall_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg                                                              |
// | Shared front-end constants: data width, reset PC, NOP, PC increment.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rv32_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'h0000_0004;

   // Sequential fetch address; wraps naturally at 2^32.
   function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] cur_pc);
      return cur_pc + PC_INC;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_counter                                                          |
// | Enable-gated event counter with synchronous reset; wraps on overflow. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module perf_counter
   import rv32_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stall_ctrl                                                      |
// | PC, IF/ID register and boot counter with flush/stall/predict priority.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_stall_ctrl
   import rv32_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_ctrl,
   input  logic            stall_cnt,
   input  logic            flush,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            predict_taken,
   input  logic [XLEN-1:0] predict_target,
   input  logic [XLEN-1:0] imem_instr,
   output logic [XLEN-1:0] pc,
   output logic [1:0]      boot_cnt,
   output logic [XLEN-1:0] IF_ID_instr,
   output logic [XLEN-1:0] IF_ID_pc,
   output logic            IF_ID_valid,
   output logic            ID_EX_bubble,
   output logic [XLEN-1:0] stall_cycles,
   output logic [XLEN-1:0] flush_count
);

   logic [XLEN-1:0] r_pc;
   logic [1:0]      r_boot_cnt;
   logic [XLEN-1:0] r_if_id_instr;
   logic [XLEN-1:0] r_if_id_pc;
   logic            r_if_id_valid;
   logic            w_stall_applied;

   // A flush overrides the freeze, so that cycle is not counted as a stall.
   assign w_stall_applied = stall_cnt & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_boot_cnt    <= 2'd0;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_pc    <= '0;
         r_if_id_valid <= 1'b0;
      end else begin
         if (r_boot_cnt != 2'd3) begin
            r_boot_cnt <= r_boot_cnt + 2'd1;
         end

         if (flush) begin
            r_pc          <= redirect_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= redirect_pc;
            r_if_id_valid <= 1'b0;
         end else if (!stall_cnt) begin
            r_pc          <= predict_taken ? predict_target : next_seq_pc(r_pc);
            r_if_id_instr <= imem_instr;
            r_if_id_pc    <= r_pc;
            r_if_id_valid <= 1'b1;
         end
      end
   end

   perf_counter #(.WIDTH(XLEN)) u_stall_perf (
      .clk   (clk),
      .rst   (rst),
      .en    (w_stall_applied),
      .count (stall_cycles)
   );

   perf_counter #(.WIDTH(XLEN)) u_flush_perf (
      .clk   (clk),
      .rst   (rst),
      .en    (flush),
      .count (flush_count)
   );

   assign pc           = r_pc;
   assign boot_cnt     = r_boot_cnt;
   assign IF_ID_instr  = r_if_id_instr;
   assign IF_ID_pc     = r_if_id_pc;
   assign IF_ID_valid  = r_if_id_valid;
   assign ID_EX_bubble = stall_ctrl | flush;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_stall_ctrl                                                   |
// | Directed stimulus with an event-level reference model and checks.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_ctrl = 1'b0;
   logic        stall_cnt = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        predict_taken = 1'b0;
   logic [31:0] predict_target = 32'h0;
   logic [31:0] imem_instr;
   logic [31:0] pc;
   logic [1:0]  boot_cnt;
   logic [31:0] IF_ID_instr;
   logic [31:0] IF_ID_pc;
   logic        IF_ID_valid;
   logic        ID_EX_bubble;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Reference state, advanced once per rising edge from the event rules.
   logic [31:0] m_pc, m_ifid_instr, m_ifid_pc, m_stall, m_flush;
   logic        m_ifid_valid;
   int          m_boot;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_instr = mem_word(pc);

   fetch_stall_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall_ctrl     (stall_ctrl),
      .stall_cnt      (stall_cnt),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .predict_taken  (predict_taken),
      .predict_target (predict_target),
      .imem_instr     (imem_instr),
      .pc             (pc),
      .boot_cnt       (boot_cnt),
      .IF_ID_instr    (IF_ID_instr),
      .IF_ID_pc       (IF_ID_pc),
      .IF_ID_valid    (IF_ID_valid),
      .ID_EX_bubble   (ID_EX_bubble),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_boot = 0; m_ifid_instr = 32'h13; m_ifid_pc = 32'h0;
         m_ifid_valid = 1'b0; m_stall = 32'h0; m_flush = 32'h0;
      end else begin
         m_boot = (m_boot >= 3) ? 3 : m_boot + 1;
         if (flush) begin
            m_flush      = m_flush + 1;
            m_pc         = redirect_pc;
            m_ifid_instr = 32'h13;
            m_ifid_pc    = redirect_pc;
            m_ifid_valid = 1'b0;
         end else if (stall_cnt) begin
            m_stall = m_stall + 1;
         end else begin
            m_ifid_instr = mem_word(m_pc);
            m_ifid_pc    = m_pc;
            m_ifid_valid = 1'b1;
            m_pc         = predict_taken ? predict_target : m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("pc", pc, m_pc);
         chk("boot_cnt", {30'h0, boot_cnt}, m_boot[31:0]);
         chk("IF_ID_instr", IF_ID_instr, m_ifid_instr);
         chk("IF_ID_pc", IF_ID_pc, m_ifid_pc);
         chk("IF_ID_valid", {31'h0, IF_ID_valid}, {31'h0, m_ifid_valid});
         chk("ID_EX_bubble", {31'h0, ID_EX_bubble}, {31'h0, stall_ctrl | flush});
         chk("stall_cycles", stall_cycles, m_stall);
         chk("flush_count", flush_count, m_flush);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stall_ctrl = 0; stall_cnt = 0; flush = 0; predict_taken = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick();
      check_en = 1'b1;
      chk("lit reset pc", pc, 32'h0);
      chk("lit reset IF_ID_instr", IF_ID_instr, 32'h0000_0013);
      chk("lit reset valid", {31'h0, IF_ID_valid}, 32'h0);

      // Reset release: boot 1,2,3,3; pc 4,8,12,16.
      rst = 0;
      tick();
      chk("lit first valid", {31'h0, IF_ID_valid}, 32'h1);
      chk("lit first IF_ID_pc", IF_ID_pc, 32'h0);
      chk("lit boot after 1", {30'h0, boot_cnt}, 32'd1);
      tick(); tick(); tick();
      chk("lit boot saturates", {30'h0, boot_cnt}, 32'd3);
      chk("lit pc 0x10", pc, 32'h10);

      // Three stall edges at pc=0x10, then resume at 0x14.
      stall_cnt = 1; stall_ctrl = 1;
      tick(); tick(); tick();
      chk("lit stall hold pc", pc, 32'h10);
      chk("lit stall IF_ID_pc", IF_ID_pc, 32'h0C);
      idle();
      tick();
      chk("lit resume pc", pc, 32'h14);
      chk("lit stall_cycles", stall_cycles, 32'd3);

      // Flush beats stall and prediction in the same cycle.
      flush = 1; redirect_pc = 32'h200; stall_cnt = 1;
      predict_taken = 1; predict_target = 32'h80;
      #1 chk("lit bubble comb", {31'h0, ID_EX_bubble}, 32'h1);
      tick();
      idle();
      chk("lit flush pc", pc, 32'h200);
      chk("lit flush instr", IF_ID_instr, 32'h0000_0013);
      chk("lit flush_count", flush_count, 32'd1);
      chk("lit stall unchanged", stall_cycles, 32'd3);

      // Predicted-taken redirect from pc=0x40.
      flush = 1; redirect_pc = 32'h40;
      tick();
      idle();
      predict_taken = 1; predict_target = 32'h80;
      tick();
      idle();
      chk("lit predict pc", pc, 32'h80);
      chk("lit predict IF_ID_pc", IF_ID_pc, 32'h40);

      // stall_ctrl alone only bubbles.
      stall_ctrl = 1;
      tick(); tick();
      idle();

      // PC wrap at the top of the address space.
      flush = 1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      idle();
      tick();
      chk("lit pc wrap", pc, 32'h0);

      // Stall counter wrap from all-ones.
      force dut.u_stall_perf.r_count = 32'hFFFF_FFFF;
      m_stall = 32'hFFFF_FFFF;
      #1 release dut.u_stall_perf.r_count;
      stall_cnt = 1;
      tick();
      idle();
      chk("lit stall wrap", stall_cycles, 32'h0);

      // Reset during an active stall and flush.
      stall_cnt = 1;
      tick();
      flush = 1; redirect_pc = 32'h300; rst = 1;
      tick();
      chk("lit rst pc", pc, 32'h0);
      chk("lit rst stall_cycles", stall_cycles, 32'h0);
      chk("lit rst flush_count", flush_count, 32'h0);
      chk("lit rst boot", {30'h0, boot_cnt}, 32'd0);
      idle(); rst = 0;
      tick();
      chk("lit boot restart", {30'h0, boot_cnt}, 32'd1);
      tick();

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
